if_fetch_ctrl: RTL and testbench

- Fetch-stage controller on the consumer side of the `pc` register.
- Each cycle it reads `PC`, issues an instruction-memory request, and captures the returned instruction into the IF/ID pipeline register.
- It generates `PC_write` back to `pc`, so the PC advances only when an instruction has actually been accepted.
- It absorbs a variable-latency instruction memory, ID-stage stalls and branch flushes. A one-entry buffer holds an instruction that returns while ID is stalled.

---
 rtl/mips_defs.sv | 22 ++
 rtl/if_fetch_ctrl_if.sv | 10 +
 rtl/if_id_reg.sv | 39 +++
 rtl/if_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared fetch-stage definitions: FSM encoding, reset constants, buffer layout.
package mips_defs;

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0c00;

  // One parked instruction: returned while ID was stalled.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_buf_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch control and imem.
interface if_fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register set with load enable and synchronous squash.
module if_id_reg
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_ADDR,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        clr,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pc4,
  input  logic [31:0] d_instr,
  output logic        q_valid,
  output logic [31:0] q_pc,
  output logic [31:0] q_pc4,
  output logic [31:0] q_instr
);

  // rst > clr > we; a clear keeps the PC fields so ID still sees the old address.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_pc    <= RESET_PC;
      q_pc4   <= RESET_PC + 32'd4;
      q_instr <= NOP;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_instr <= NOP;
    end else if (we) begin
      q_valid <= 1'b1;
      q_pc    <= d_pc;
      q_pc4   <= d_pc4;
      q_instr <= d_instr;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: issues imem requests, fills IF/ID, drives PC_write.
module if_fetch_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_ADDR,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  NPC_redirect,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  PC_write,
  if_fetch_ctrl_if.master       imem,
  output logic                  IF_ID_valid,
  output logic [31:0]           IF_ID_PC,
  output logic [31:0]           IF_ID_PC4,
  output logic [31:0]           IF_ID_instr,
  output logic [31:0]           fetch_wait_cnt
);

  fetch_state_e state_q;
  fetch_buf_t   buf_q;
  logic [31:0]  wait_cnt_q;

  logic        reg_we;
  logic        reg_clr;
  logic [31:0] reg_d_pc;
  logic [31:0] reg_d_instr;

  // flush without a redirect is only a bubble: no PC load, state and buffer kept.
  logic flush_redirect;
  assign flush_redirect = flush & NPC_redirect;

  // Request, PC_write and IF/ID load/clear decode for the current cycle.
  always_comb begin
    imem.req    = (state_q == S_REQ) && !rst;
    imem.addr   = PC;
    PC_write    = 1'b0;
    reg_we      = 1'b0;
    reg_clr     = 1'b0;
    reg_d_pc    = PC;
    reg_d_instr = imem.rdata;
    if (!rst) begin
      if (flush) begin
        reg_clr  = 1'b1;
        PC_write = NPC_redirect;
      end else if (state_q == S_BUF) begin
        if (!stall) begin
          reg_we      = 1'b1;
          reg_d_pc    = buf_q.pc;
          reg_d_instr = buf_q.instr;
          PC_write    = 1'b1;
        end
      end else if (imem.ack) begin
        if (!stall) begin
          reg_we   = 1'b1;
          PC_write = 1'b1;
        end
      end else if (!stall) begin
        reg_clr = 1'b1;
      end
    end
  end

  // FSM, one-entry buffer and saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      buf_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      // Counts every requesting cycle without ack, whatever stall/flush do.
      if (state_q == S_REQ && !imem.ack && wait_cnt_q != 32'hFFFF_FFFF) begin
        wait_cnt_q <= wait_cnt_q + 32'd1;
      end
      if (flush) begin
        if (flush_redirect) begin
          state_q <= S_REQ;
          buf_q   <= '0;
        end
      end else begin
        case (state_q)
          S_REQ: begin
            if (imem.ack && stall) begin
              buf_q.pc    <= PC;
              buf_q.instr <= imem.rdata;
              state_q     <= S_BUF;
            end
          end
          S_BUF: begin
            if (!stall) state_q <= S_REQ;
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign fetch_wait_cnt = wait_cnt_q;

  if_id_reg #(
    .RESET_PC(RESET_PC),
    .NOP     (NOP)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we),
    .clr    (reg_clr),
    .d_pc   (reg_d_pc),
    .d_pc4  (pc_plus4(reg_d_pc)),
    .d_instr(reg_d_instr),
    .q_valid(IF_ID_valid),
    .q_pc   (IF_ID_PC),
    .q_pc4  (IF_ID_PC4),
    .q_instr(IF_ID_instr)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural fetch/pipeline model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0c00;

  logic        clk;
  logic        rst;
  logic [31:0] tb_pc;
  logic        NPC_redirect;
  logic        stall;
  logic        flush;
  logic        PC_write;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_instr;
  logic [31:0] fetch_wait_cnt;
  logic [31:0] target;

  if_fetch_ctrl_if imem ();

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .PC            (tb_pc),
    .NPC_redirect  (NPC_redirect),
    .stall         (stall),
    .flush         (flush),
    .PC_write      (PC_write),
    .imem          (imem.master),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_instr   (IF_ID_instr),
    .fetch_wait_cnt(fetch_wait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the IF/ID contents, an optional parked instruction, wait count.
  bit          model_ok = 1'b0;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_full;
  logic [31:0] m_buf_pc;
  logic [31:0] m_buf_instr;
  logic [31:0] m_cnt;
  bit          m_pcw;

  // Memory is asked only when nothing is parked.
  function automatic bit exp_req();
    return !rst && !m_full;
  endfunction

  // An instruction is accepted into IF/ID (or a real redirect happens) => pc advances.
  function automatic bit exp_pcw();
    if (rst) return 1'b0;
    if (flush) return NPC_redirect;
    if (m_full) return !stall;
    return imem.ack && !stall;
  endfunction

  always @(posedge clk) begin
    m_pcw = exp_pcw();
    if (rst) begin
      tb_pc    <= RST_PC;
      m_valid  = 1'b0;
      m_pc     = RST_PC;
      m_instr  = 32'h0;
      m_full   = 1'b0;
      m_cnt    = 32'h0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_pcw) tb_pc <= flush ? target : tb_pc + 32'd4;
      if (!m_full && !imem.ack && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_valid = 1'b0;
        m_instr = 32'h0;
        if (NPC_redirect) m_full = 1'b0;
      end else if (m_full) begin
        if (!stall) begin
          m_valid = 1'b1;
          m_pc    = m_buf_pc;
          m_instr = m_buf_instr;
          m_full  = 1'b0;
        end
      end else if (imem.ack) begin
        if (stall) begin
          m_full      = 1'b1;
          m_buf_pc    = tb_pc;
          m_buf_instr = imem.rdata;
        end else begin
          m_valid = 1'b1;
          m_pc    = tb_pc;
          m_instr = imem.rdata;
        end
      end else if (!stall) begin
        m_valid = 1'b0;
        m_instr = 32'h0;
      end
    end
  end

  // Per-cycle comparison, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("imem_req", 32'(imem.req), 32'(exp_req()));
      chk("PC_write", 32'(PC_write), 32'(exp_pcw()));
      chk("imem_addr", imem.addr, tb_pc);
      chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
      chk("IF_ID_PC", IF_ID_PC, m_pc);
      chk("IF_ID_PC4", IF_ID_PC4, m_pc + 32'd4);
      chk("IF_ID_instr", IF_ID_instr, m_instr);
      chk("fetch_wait_cnt", fetch_wait_cnt, m_cnt);
    end
  end

  // Drive one cycle's inputs just after the edge; return after the mid-cycle compare.
  task automatic cyc(input bit r, input bit s, input bit f, input bit red, input bit a,
                     input logic [31:0] rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst          = r;
    stall        = s;
    flush        = f;
    NPC_redirect = red;
    imem.ack     = a;
    imem.rdata   = rd;
    target       = tgt;
    #5;
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    NPC_redirect = 1'b0;
    imem.ack     = 1'b0;
    imem.rdata   = 32'h0;
    target       = 32'h0;

    // Reset: no request, no PC load.
    cyc(1, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("rst_req", 32'(imem.req), 32'h0);
    chk("rst_pcw", 32'(PC_write), 32'h0);

    // Streaming at zero wait.
    cyc(0, 0, 0, 0, 1, 32'hA000_0000, 32'h0);
    chk("stream_pcw", 32'(PC_write), 32'h1);
    chk("reset_if_pc", IF_ID_PC, 32'h0000_0c00);
    chk("reset_valid", 32'(IF_ID_valid), 32'h0);
    cyc(0, 0, 0, 0, 1, 32'hA000_0001, 32'h0);
    chk("first_if_pc", IF_ID_PC, 32'h0000_0c00);
    chk("first_instr", IF_ID_instr, 32'hA000_0000);
    chk("pc_step", tb_pc, 32'h0000_0c04);

    // Three missing acks at 0x0c08.
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("wait_pcw0", 32'(PC_write), 32'h0);
    chk("second_if_pc", IF_ID_PC, 32'h0000_0c04);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("bubble_valid", 32'(IF_ID_valid), 32'h0);
    cyc(0, 0, 0, 0, 1, 32'hA000_0002, 32'h0);
    chk("wait_cnt3", fetch_wait_cnt, 32'h3);
    chk("wait_pc", tb_pc, 32'h0000_0c08);

    // Ack under stall parks the word.
    cyc(0, 1, 0, 0, 1, 32'h2402_0005, 32'h0);
    chk("after_wait_pc", IF_ID_PC, 32'h0000_0c08);
    cyc(0, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0);
    chk("buf_req", 32'(imem.req), 32'h0);
    chk("buf_hold_pc", IF_ID_PC, 32'h0000_0c08);
    cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("buf_hold_instr", IF_ID_instr, 32'hA000_0002);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("unstall_pcw", 32'(PC_write), 32'h1);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("unbuf_instr", IF_ID_instr, 32'h2402_0005);
    chk("unbuf_pc", IF_ID_PC, 32'h0000_0c0c);
    chk("unbuf_next_pc", tb_pc, 32'h0000_0c10);

    // Flush while a word is parked.
    cyc(0, 1, 0, 0, 1, 32'hB000_0000, 32'h0);
    cyc(0, 1, 1, 1, 0, 32'h0, 32'h0000_2000);
    chk("flushbuf_req", 32'(imem.req), 32'h0);
    chk("flushbuf_pcw", 32'(PC_write), 32'h1);
    cyc(0, 0, 0, 0, 1, 32'hB000_0001, 32'h0);
    chk("flushbuf_valid", 32'(IF_ID_valid), 32'h0);
    chk("flushbuf_instr", IF_ID_instr, 32'h0);
    chk("flushbuf_pc_held", IF_ID_PC, 32'h0000_0c0c);
    chk("flushbuf_target", tb_pc, 32'h0000_2000);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("target_fetched", IF_ID_PC, 32'h0000_2000);
    chk("target_instr", IF_ID_instr, 32'hB000_0001);

    // Flush with ack and stall together.
    cyc(0, 1, 1, 1, 1, 32'hC000_0000, 32'h0000_3000);
    chk("flushall_pcw", 32'(PC_write), 32'h1);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("flushall_valid", 32'(IF_ID_valid), 32'h0);
    chk("flushall_req", 32'(imem.req), 32'h1);
    chk("flushall_pc", tb_pc, 32'h0000_3000);

    // Flush without redirect: bubble only.
    cyc(0, 0, 1, 0, 1, 32'hD000_0000, 32'h0000_4000);
    chk("badflush_pcw", 32'(PC_write), 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("badflush_valid", 32'(IF_ID_valid), 32'h0);
    chk("badflush_pc", tb_pc, 32'h0000_3000);

    // Reset while a word is parked.
    cyc(0, 1, 0, 0, 1, 32'hE000_0000, 32'h0);
    cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("rstbuf_req0", 32'(imem.req), 32'h0);
    cyc(1, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("rstbuf_req", 32'(imem.req), 32'h0);
    chk("rstbuf_pcw", 32'(PC_write), 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("rstbuf_valid", 32'(IF_ID_valid), 32'h0);
    chk("rstbuf_pc", IF_ID_PC, 32'h0000_0c00);
    chk("rstbuf_pc4", IF_ID_PC4, 32'h0000_0c04);
    chk("rstbuf_cnt", fetch_wait_cnt, 32'h0);
    chk("rstbuf_req1", 32'(imem.req), 32'h1);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 800; i++) begin
      bit r, s, f, red, a;
      r   = ($urandom_range(99) == 0);
      f   = ($urandom_range(15) == 0);
      red = f ? 1'b1 : 1'($urandom_range(1));
      a   = ($urandom_range(9) < 7);
      s   = ($urandom_range(3) == 0);
      cyc(r, s, f, red, a, $urandom, $urandom & 32'hFFFF_FFFC);
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
